log_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `logarithm` unit (Q16.16 ln(x), start-pulse/valid interface) between NREQ requesters in the pricing datapath. The block accepts one request at a time and issues a one-cycle start pulse to the shared unit. It waits for the result and returns it to the granted requester with a one-cycle response strobe. An optional watchdog aborts operations whose result never arrives.

---
 rtl/log_arbiter.sv | 175 +++++++++++++++++
 tb/tb_log_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_arbiter.sv
// rtl/log_arbiter.sv - round-robin sequencer sharing one Q16.16 ln(x) unit; optional watchdog under LOG_ARB_TIMEOUT_EN
module log_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  log_start,
   output logic [WIDTH-1:0]      log_in,
   input  logic [WIDTH-1:0]      log_out,
   input  logic                  log_valid
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    gnt_q, gnt_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             seen_low_q, seen_low_d;
   logic             valid_prev_q, valid_prev_d;

   logic [IW-1:0]    pick;
   logic             pick_found;
   int               pick_idx;
   logic             accept;

`ifdef LOG_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
`else
   logic             unused_timeout;
   assign unused_timeout = |TIMEOUT;
`endif

   // A fresh result needs a low level first, either earlier in WAIT or in the cycle before
   assign accept = log_valid && (seen_low_q || !valid_prev_q);
   assign busy   = (state_q != S_IDLE);
   assign log_in = op_q;

   // Round-robin search: first requesting index at or after ptr, wrapping
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      pick_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         pick_idx = (int'(ptr_q) + k) % NREQ;
         if (!pick_found && req_valid[pick_idx]) begin
            pick       = pick_idx[IW-1:0];
            pick_found = 1'b1;
         end
      end
   end

   // Sequencer next-state and outputs
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gnt_d        = gnt_q;
      op_d         = op_q;
      res_d        = res_q;
      seen_low_d   = seen_low_q;
      valid_prev_d = log_valid;
`ifdef LOG_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_q;
`endif
      req_ready    = '0;
      rsp_valid    = '0;
      rsp_data     = '0;
      rsp_err      = 1'b0;
      log_start    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Gated by reset so nothing is acknowledged in a cycle that will be discarded
            if (pick_found && !reset) begin
               req_ready = {{(NREQ-1){1'b0}}, 1'b1} << pick;
               op_d      = req_data[int'(pick)*WIDTH +: WIDTH];
               gnt_d     = pick;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            log_start  = 1'b1;
            seen_low_d = 1'b0;
`ifdef LOG_ARB_TIMEOUT_EN
            cnt_d      = '0;
`endif
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (!log_valid) begin
               seen_low_d = 1'b1;
            end
`ifdef LOG_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
            if (accept) begin
               res_d   = log_out;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_d   = {1'b1, {(WIDTH-1){1'b0}}};
               err_d   = 1'b1;
               state_d = S_RESP;
            end
`else
            if (accept) begin
               res_d   = log_out;
               state_d = S_RESP;
            end
`endif
         end
         S_RESP: begin
            rsp_valid = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
            rsp_data  = res_q;
`ifdef LOG_ARB_TIMEOUT_EN
            rsp_err   = err_q;
`endif
            ptr_d     = IW'((int'(gnt_q) + 1) % NREQ);
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         gnt_q        <= '0;
         op_q         <= '0;
         res_q        <= '0;
         seen_low_q   <= 1'b0;
         valid_prev_q <= 1'b0;
`ifdef LOG_ARB_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         op_q         <= op_d;
         res_q        <= res_d;
         seen_low_q   <= seen_low_d;
         valid_prev_q <= valid_prev_d;
`ifdef LOG_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_log_arbiter.sv
// tb/tb_log_arbiter.sv - scoreboard bench for log_arbiter with a behavioural ln unit
`timescale 1ns/1ps
module tb_log_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic                  log_start;
   logic [WIDTH-1:0]      log_in;
   logic [WIDTH-1:0]      log_out;
   logic                  log_valid;

   always #5 clk = ~clk;

   log_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .log_start(log_start), .log_in(log_in),
      .log_out(log_out), .log_valid(log_valid)
   );

   typedef struct packed {
      logic [3:0]  onehot;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   rsp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   int          unit_lat = 3;
   logic        hold_mode = 1'b0;
   logic        never_mode = 1'b0;
   int          cd = 0;
   logic [31:0] op_l;
   logic        ok;
   int          cyc;
   // requester i sends 0x0010000i; the unit swaps halves -> 0x000i0010
   logic [31:0] exp_res [4] = '{32'h00000010, 32'h00010010, 32'h00020010, 32'h00030010};

   function automatic logic [31:0] unit_fn(input logic [31:0] x);
      if (x == 32'h00020000) return 32'h0000B172;
      return {x[15:0], x[31:16]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int g, input logic [31:0] d, input logic e);
      rsp_t r;
      r.onehot = 4'(1 << g);
      r.data   = d;
      r.err    = e;
      exp_q.push_back(r);
   endtask

   // Behavioural shared unit: result unit_lat cycles after start, optional stale hold
   initial begin
      log_valid = 1'b0;
      log_out   = '0;
      op_l      = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            log_valid = 1'b0;
            cd        = 0;
         end else begin
            if (!hold_mode) log_valid = 1'b0;
            if (cd > 0) begin
               cd--;
               if (hold_mode && cd == 2) log_valid = 1'b0;
               if (cd == 0 && !never_mode) begin
                  log_valid = 1'b1;
                  log_out   = unit_fn(op_l);
               end
            end
            if (log_start) begin
               op_l = log_in;
               cd   = unit_lat;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every response, checks idle zeros otherwise
   always @(negedge clk) begin
      if (mon_en) begin
         if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.onehot));
               chk("rsp_data", rsp_data, mon_e.data);
               chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
         end else begin
            chk("idle_rsp_data", rsp_data, 32'h0);
            chk("idle_rsp_err", 32'(rsp_err), 32'h0);
         end
      end
   end

   task automatic wait_ready(output logic got);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_ready: no req_ready within 100 cycles");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) break;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'h0);
      chk("drain_busy", 32'(busy), 32'h0);
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      reset     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_log_start"}, 32'(log_start), 32'h0);
      chk({tag, "_log_in"}, log_in, 32'h0);
   endtask

   // Raise mask, expect grants in order seq (one nibble per grant); optionally drop each served requester
   task automatic grant_seq(input logic [3:0] mask, input int n, input logic [31:0] seq, input logic drop);
      logic got;
      int   g;
      @(posedge clk); #1;
      req_valid = mask;
      for (int k = 0; k < n; k++) begin
         g = int'(seq[k*4 +: 4]);
         push(g, exp_res[g], 1'b0);
         wait_ready(got);
         chk("grant", 32'(req_ready), 32'(1 << g));
         @(posedge clk); #1;
         if (drop) req_valid[g] = 1'b0;
      end
      req_valid = '0;
   endtask

   initial begin
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 32'h00100000 | 32'(i);
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      check_all_zero("reset");

      // single request from requester 2
      req_data[2*WIDTH +: WIDTH] = 32'h00020000;
      @(posedge clk); #1;
      req_valid = 4'b0100;
      push(2, 32'h0000B172, 1'b0);
      @(negedge clk);
      chk("t1_ready", 32'(req_ready), 32'h4);
      chk("t1_start_early", 32'(log_start), 32'h0);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("t1_start", 32'(log_start), 32'h1);
      chk("t1_log_in", log_in, 32'h00020000);
      chk("t1_ready_off", 32'(req_ready), 32'h0);
      chk("t1_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("t1_start_pulse", 32'(log_start), 32'h0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (log_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("t1_unit_valid", 32'(ok), 32'h1);
      chk("t1_rsp_not_yet", 32'(rsp_valid), 32'h0);
      chk("t1_log_in_held", log_in, 32'h00020000);
      @(negedge clk);
      chk("t1_rsp_strobe", 32'(rsp_valid), 32'h4);
      drain();
      req_data[2*WIDTH +: WIDTH] = 32'h00100002;

      // full contention after reset: 0,1,2,3,0,1
      do_reset();
      grant_seq(4'b1111, 6, 32'h00103210, 1'b0);
      drain();

      // partial contention with ptr=1: 3 before 0
      do_reset();
      grant_seq(4'b0001, 1, 32'h0, 1'b1);
      drain();
      grant_seq(4'b1001, 2, 32'h03, 1'b1);
      drain();

      // stale valid held from the previous result
      do_reset();
      hold_mode = 1'b1;
      unit_lat  = 5;
      grant_seq(4'b0011, 2, 32'h10, 1'b1);
      drain();
      grant_seq(4'b0111, 3, 32'h102, 1'b1);
      drain();
      hold_mode = 1'b0;
      unit_lat  = 3;

`ifdef LOG_ARB_TIMEOUT_EN
      // watchdog: unit never answers
      do_reset();
      never_mode = 1'b1;
      @(posedge clk); #1;
      req_valid = 4'b0010;
      push(1, 32'h80000000, 1'b1);
      wait_ready(ok);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("to_start", 32'(log_start), 32'h1);
      cyc = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid != '0) break;
      end
      chk("to_latency", 32'(cyc), 32'd9);
      never_mode = 1'b0;
      drain();
      grant_seq(4'b0100, 1, 32'h2, 1'b1);
      drain();
`endif

      // reset while in WAIT
      do_reset();
      grant_seq(4'b0100, 1, 32'h2, 1'b1);
      drain();
      unit_lat = 10;
      @(posedge clk); #1;
      req_valid = 4'b1000;
      wait_ready(ok);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (3) @(negedge clk);
      chk("mid_wait_busy", 32'(busy), 32'h1);
      do_reset();
      @(negedge clk);
      check_all_zero("post_reset");
      repeat (12) @(negedge clk);
      unit_lat = 3;
      grant_seq(4'b1001, 2, 32'h30, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "global timeout");
   end

endmodule
